// File: rtl/rotate_shift_seq.sv
// Sequenced rotate/shift register: parallel load, then N rotate/shift steps with busy/done handshake.
// Optional macro ROTSEQ_BARREL_EN applies all N steps on a single RUN edge instead of one per cycle.
module rotate_shift_seq #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [STEP_W-1:0] steps,
   input  logic              ser_in,
   output logic [WIDTH-1:0]  data_out,
   output logic              ser_out,
   output logic              busy,
   output logic              done
);

   localparam int MAX_STEPS = (1 << STEP_W) - 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              ser_q, ser_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic [1:0]        mode_q, mode_d;
   logic [WIDTH:0]    step_s;
   logic              last_s;

   // Returns {exiting bit, new word} for one step in the given mode.
   function automatic logic [WIDTH:0] step_one(input logic [WIDTH-1:0] w,
                                               input logic [1:0]       m,
                                               input logic             fill);
      logic [WIDTH:0] r;
      case (m)
         2'b00:   r = {w[0], w[0], w[WIDTH-1:1]};
         2'b01:   r = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
         2'b10:   r = {w[0], fill, w[WIDTH-1:1]};
         2'b11:   r = {w[WIDTH-1], w[WIDTH-2:0], fill};
         default: r = {1'b0, w};
      endcase
      return r;
   endfunction

   // Chains n single steps; the last exiting bit becomes ser_out.
   function automatic logic [WIDTH:0] step_n(input logic [WIDTH-1:0]  w,
                                             input logic [1:0]        m,
                                             input logic              fill,
                                             input logic [STEP_W-1:0] n,
                                             input logic              so);
      logic [WIDTH:0] acc;
      acc = {so, w};
      for (int i = 0; i < MAX_STEPS; i++) begin
         if (STEP_W'(i) < n) begin
            acc = step_one(acc[WIDTH-1:0], m, fill);
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction

   // Step datapath: one bit per edge, or the whole count at once in the barrel build.
   always_comb begin
`ifdef ROTSEQ_BARREL_EN
      step_s = step_n(data_q, mode_q, ser_in, cnt_q, ser_q);
      last_s = 1'b1;
`else
      step_s = step_one(data_q, mode_q, ser_in);
      last_s = (cnt_q == STEP_W'(1));
`endif
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= {WIDTH{1'b0}};
         ser_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= {STEP_W{1'b0}};
         mode_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ser_q   <= ser_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state logic; load always wins and aborts a running sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = IDLE;
            end else if (start && (steps != {STEP_W{1'b0}})) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (load || last_s) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and handshake outputs.
   always_comb begin
      data_d = data_q;
      ser_d  = ser_q;
      busy_d = busy_q;
      done_d = 1'b0;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               data_d = data_in;
            end else if (start && (steps != {STEP_W{1'b0}})) begin
               mode_d = mode;
               cnt_d  = steps;
               busy_d = 1'b1;
            end else if (start) begin
               done_d = 1'b1;
            end else begin
               done_d = 1'b0;
            end
         end
         RUN: begin
            if (load) begin
               data_d = data_in;
               busy_d = 1'b0;
               cnt_d  = {STEP_W{1'b0}};
            end else begin
               {ser_d, data_d} = step_s;
               if (last_s) begin
                  cnt_d  = {STEP_W{1'b0}};
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  cnt_d  = cnt_q - STEP_W'(1);
               end
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign data_out = data_q;
   assign ser_out  = ser_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_rotate_shift_seq.sv
// Self-checking bench for rotate_shift_seq: directed scenarios plus random commands
// against a word-level reference model. Works with or without ROTSEQ_BARREL_EN.
module tb_rotate_shift_seq;

   localparam int W = 8;
`ifdef ROTSEQ_BARREL_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic [7:0] data_in;
   logic       start;
   logic [1:0] mode;
   logic [3:0] steps;
   logic       ser_in;
   logic [7:0] data_out;
   logic       ser_out;
   logic       busy;
   logic       done;

   int   checks   = 0;
   int   failures = 0;
   logic ser_exp  = 1'b0;

   rotate_shift_seq #(.WIDTH(8), .STEP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .start(start),
      .mode(mode), .steps(steps), .ser_in(ser_in), .data_out(data_out),
      .ser_out(ser_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Whole-word result of an n-step command: rotate by n mod W, shift with fill mask.
   function automatic void model(input logic [7:0] w, input logic [1:0] m, input int n,
                                 input logic s, input logic so_prev,
                                 output logic [7:0] r, output logic so);
      logic [15:0] dbl;
      logic [7:0]  msk;
      int          k;
      r  = w;
      so = so_prev;
      if (n == 0) return;
      k   = n % W;
      dbl = {w, w};
      case (m)
         2'd0: begin dbl = dbl >> k; r = dbl[7:0];  so = w[(n-1) % W]; end
         2'd1: begin dbl = dbl << k; r = dbl[15:8]; so = w[W-1-((n-1) % W)]; end
         2'd2: begin
            msk = s ? ~(8'hFF >> n) : 8'h00;
            r   = (n >= W) ? {8{s}} : ((w >> n) | msk);
            so  = (n <= W) ? w[n-1] : s;
         end
         default: begin
            msk = s ? ~(8'hFF << n) : 8'h00;
            r   = (n >= W) ? {8{s}} : ((w << n) | msk);
            so  = (n <= W) ? w[W-n] : s;
         end
      endcase
   endfunction

   task automatic do_load(input logic [7:0] d);
      load = 1'b1; data_in = d;
      tick();
      load = 1'b0;
      check("load_data", data_out, d);
   endtask

   // Load, start an n-step command, wait bounded for done, compare against the model.
   task automatic run_cmd(input logic [7:0] d, input logic [1:0] m, input int n,
                          input logic s, input bit poke);
      logic [7:0] er;
      logic       eso;
      int         lat;
      int         c;
      do_load(d);
      model(d, m, n, s, ser_exp, er, eso);
      lat = (n == 0) ? 0 : (BARREL ? 1 : n);
      mode = m; steps = 4'(n); ser_in = s; start = 1'b1;
      tick();
      start = 1'b0;
      c = 0;
      while (!done && c < 40) begin
         check("busy_run", {31'd0, busy}, 32'd1);
         if (poke && c == 0) begin
            start = 1'b1; mode = ~m; steps = 4'd1;
         end
         tick();
         start = 1'b0;
         c++;
      end
      check("latency", c, lat);
      check("done_no_busy", {31'd0, busy}, 32'd0);
      check("result", data_out, er);
      check("ser_out", {31'd0, ser_out}, {31'd0, eso});
      ser_exp = eso;
      tick();
      check("done_pulse", {31'd0, done}, 32'd0);
      check("idle_after", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] er;
      logic       eso;
      rst_n = 1'b0; load = 1'b0; data_in = 8'h00; start = 1'b0;
      mode = 2'b00; steps = 4'd0; ser_in = 1'b0;
      tick(); tick();
      check("rst_data", data_out, 8'h00);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ser", {31'd0, ser_out}, 32'd0);
      rst_n = 1'b1;
      tick();

      run_cmd(8'hB1, 2'b00, 1, 1'b0, 1'b0);
      check("b1_rotr1", data_out, 8'hD8);
      run_cmd(8'h81, 2'b01, 3, 1'b0, 1'b0);
      check("81_rotl3", data_out, 8'h0C);
      run_cmd(8'h00, 2'b10, 4, 1'b1, 1'b0);
      check("00_shr4", data_out, 8'hF0);
      run_cmd(8'hFF, 2'b11, 9, 1'b0, 1'b0);
      check("ff_shl9", data_out, 8'h00);
      run_cmd(8'hA5, 2'b00, 8, 1'b1, 1'b0);
      check("a5_rotr8", data_out, 8'hA5);
      run_cmd(8'h3C, 2'b00, 0, 1'b1, 1'b0);
      run_cmd(8'h3C, 2'b00, 4, 1'b0, 1'b1);
      check("start_ignored", data_out, 8'hC3);

      if (!BARREL) begin
         do_load(8'h5A);
         mode = 2'b00; steps = 4'd5; start = 1'b1;
         tick();
         start = 1'b0;
         tick(); tick();
         model(8'h5A, 2'b00, 2, 1'b0, ser_exp, er, eso);
         load = 1'b1; data_in = 8'h3C;
         tick();
         load = 1'b0;
         check("abort_data", data_out, 8'h3C);
         check("abort_busy", {31'd0, busy}, 32'd0);
         check("abort_done", {31'd0, done}, 32'd0);
         check("abort_ser", {31'd0, ser_out}, {31'd0, eso});
         ser_exp = eso;
         tick();
         check("abort_no_done", {31'd0, done}, 32'd0);
      end

      do_load(8'h11);
      load = 1'b1; data_in = 8'h96; start = 1'b1; steps = 4'd3; mode = 2'b01;
      tick();
      load = 1'b0; start = 1'b0;
      check("ld_start_data", data_out, 8'h96);
      check("ld_start_busy", {31'd0, busy}, 32'd0);
      check("ld_start_done", {31'd0, done}, 32'd0);
      tick();
      check("ld_start_quiet", {31'd0, busy | done}, 32'd0);

      for (int i = 0; i < 24; i++) begin
         rd = 8'($urandom);
         run_cmd(rd, 2'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'b0);
      end

      do_load(8'hFF);
      mode = 2'b00; steps = 4'd10; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("async_rst_data", data_out, 8'h00);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_done", {31'd0, done}, 32'd0);
      check("async_rst_ser", {31'd0, ser_out}, 32'd0);
      rst_n = 1'b1;
      ser_exp = 1'b0;
      tick();
      check("post_rst_idle", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
